// File: rtl/switch_arb_pkg.sv
// Shared definitions for the switch output arbiter: FSM state encoding and
// the reset value convention for the round-robin last-winner pointer.
package switch_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  // Last pointer resets to the highest port so that port 0 is checked first.
  function automatic int unsigned reset_last(input int unsigned ports);
    return ports - 32'd1;
  endfunction

endpackage

// File: rtl/switch_output_arbiter_if.sv
// Request/ack bundle between the RX units, the output arbiter and the TX unit.
// The master modport is the arbiter side; slave is the RX/TX environment side.
interface switch_output_arbiter_if #(
  parameter int PORTS     = 5,
  parameter int PORT_BITS = 8
);

  logic [PORTS-1:0]     reqs_in;
  logic [PORTS-1:0]     acks_in;
  logic                 req_out;
  logic                 ack_out;
  logic [PORT_BITS-1:0] selected;
  logic                 active;

  modport master (
    input  reqs_in,
    input  ack_out,
    output acks_in,
    output req_out,
    output selected,
    output active
  );

  modport slave (
    output reqs_in,
    output ack_out,
    input  acks_in,
    input  req_out,
    input  selected,
    input  active
  );

endinterface

// File: rtl/arb_rr_picker.sv
// Combinational winner selection: round-robin starting after last_i, or
// lowest-index-wins when ARB_FIXED_PRIO_EN is defined.
module arb_rr_picker #(
  parameter int PORTS     = 5,
  parameter int PORT_BITS = 8
) (
  input  logic [PORTS-1:0]     reqs_i,
  input  logic [PORT_BITS-1:0] last_i,
  output logic [PORT_BITS-1:0] winner_o,
  output logic                 any_o
);

  logic found_s;

  assign any_o = |reqs_i;

`ifdef ARB_FIXED_PRIO_EN
  logic unused_last_s;
  assign unused_last_s = ^last_i;

  // Lowest requesting index wins.
  always_comb begin
    winner_o = '0;
    found_s  = 1'b0;
    for (int j = 0; j < PORTS; j++) begin
      if (!found_s && reqs_i[j]) begin
        winner_o = PORT_BITS'(j);
        found_s  = 1'b1;
      end else begin
        found_s  = found_s;
      end
    end
  end
`else
  int idx_s;

  // Scan PORTS positions starting at last+1, wrapping past PORTS-1 to 0.
  always_comb begin
    winner_o = '0;
    found_s  = 1'b0;
    idx_s    = 0;
    for (int i = 1; i <= PORTS; i++) begin
      idx_s = int'(last_i) + i;
      if (idx_s >= PORTS) begin
        idx_s = idx_s - PORTS;
      end else begin
        idx_s = idx_s;
      end
      for (int j = 0; j < PORTS; j++) begin
        if (!found_s && (j == idx_s) && reqs_i[j]) begin
          winner_o = PORT_BITS'(j);
          found_s  = 1'b1;
        end else begin
          found_s  = found_s;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/switch_output_arbiter.sv
// Per-output-port arbiter: picks one requesting RX unit, runs a 4-phase
// req/ack with the TX unit and returns the ack. Fixed priority: ARB_FIXED_PRIO_EN.
module switch_output_arbiter
  import switch_arb_pkg::*;
#(
  parameter int ID        = 0,
  parameter int SUBID     = 0,
  parameter int PORTS     = 5,
  parameter int PORT_BITS = 8
) (
  input logic                     clk,
  input logic                     reset,
  switch_output_arbiter_if.master bus
);

  localparam logic [PORT_BITS-1:0] RESET_LAST_IDX = PORT_BITS'(reset_last(PORTS));

  arb_state_e           state_q, state_d;
  logic [PORT_BITS-1:0] sel_q, sel_d;
  logic [PORT_BITS-1:0] last_q, last_d;
  logic [PORTS-1:0]     acks_q, acks_d;
  logic                 req_q, req_d;
  logic                 active_q, active_d;

  logic [PORT_BITS-1:0] winner_s;
  logic                 any_s;
  logic                 win_req_s;
  logic [31:0]          unused_id_s;

  assign unused_id_s = 32'(ID) ^ 32'(SUBID);

  arb_rr_picker #(
    .PORTS     (PORTS),
    .PORT_BITS (PORT_BITS)
  ) u_picker (
    .reqs_i   (bus.reqs_in),
    .last_i   (last_q),
    .winner_o (winner_s),
    .any_o    (any_s)
  );

  // In RELEASE acks_q is one-hot on the winner, so this is reqs_in[w].
  assign win_req_s = |(bus.reqs_in & acks_q);

  // Next-state and output decode of the handshake FSM.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    acks_d   = acks_q;
    req_d    = req_q;
    active_d = active_q;
    case (state_q)
      IDLE: begin
        if (any_s) begin
          sel_d    = winner_s;
          active_d = 1'b1;
          req_d    = 1'b1;
          state_d  = GRANT;
        end else begin
          state_d  = IDLE;
        end
      end
      GRANT: begin
        if (bus.ack_out) begin
          req_d   = 1'b0;
          for (int j = 0; j < PORTS; j++) begin
            acks_d[j] = (sel_q == PORT_BITS'(j));
          end
          state_d = RELEASE;
        end else begin
          state_d = GRANT;
        end
      end
      RELEASE: begin
        if (!win_req_s && !bus.ack_out) begin
          acks_d   = '0;
          active_d = 1'b0;
          last_d   = sel_q;
          state_d  = IDLE;
        end else begin
          state_d  = RELEASE;
        end
      end
      default: begin
        acks_d   = '0;
        req_d    = 1'b0;
        active_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any pending connection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      last_q   <= RESET_LAST_IDX;
      acks_q   <= '0;
      req_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      acks_q   <= acks_d;
      req_q    <= req_d;
      active_q <= active_d;
    end
  end

  assign bus.acks_in  = acks_q;
  assign bus.req_out  = req_q;
  assign bus.selected = sel_q;
  assign bus.active   = active_q;

endmodule

// File: tb/tb_switch_output_arbiter.sv
// Scoreboard bench for switch_output_arbiter: expected winners are queued
// when requests are driven and compared when req_out rises.
module tb_switch_output_arbiter;

  logic       clk;
  logic       reset;
  logic [4:0] reqs;
  logic       ack;

  int n_tests;
  int n_fail;
  int exp_q[$];
  int last_m;

  switch_output_arbiter_if #(.PORTS(5), .PORT_BITS(8)) bus ();

  assign bus.reqs_in = reqs;
  assign bus.ack_out = ack;

  switch_output_arbiter #(
    .ID        (0),
    .SUBID     (0),
    .PORTS     (5),
    .PORT_BITS (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int model_pick(input logic [4:0] r);
    int idx;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < 5; i++) begin
      idx = i;
      if (r[idx[2:0]]) return idx;
    end
`else
    for (int k = 1; k <= 5; k++) begin
      idx = (last_m + k) % 5;
      if (r[idx[2:0]]) return idx;
    end
`endif
    return -1;
  endfunction

  task automatic expect_grant();
    exp_q.push_back(model_pick(reqs));
  endtask

  task automatic wait_grant(output int w);
    int n;
    n = 0;
    while (bus.req_out !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("grant_seen", 32'(bus.req_out), 32'd1);
    chk("grant_latency", n, 32'd1);
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
    end else begin
      w = 0;
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
    end
    chk("selected", 32'(bus.selected), w);
    chk("active_grant", 32'(bus.active), 32'd1);
  endtask

  task automatic finish_conn(input int w, input bit rereq);
    logic [4:0] oh;
    oh = 5'b00001 << w;
    ack = 1'b1;
    @(negedge clk);
    chk("ack_onehot", 32'(bus.acks_in), 32'(oh));
    chk("req_dropped", 32'(bus.req_out), 32'd0);
    ack  = 1'b0;
    reqs = reqs & ~oh;
    @(negedge clk);
    chk("ack_cleared", 32'(bus.acks_in), 32'd0);
    chk("active_cleared", 32'(bus.active), 32'd0);
    chk("selected_kept", 32'(bus.selected), w);
    last_m = w;
    if (rereq) reqs = reqs | oh;
  endtask

  initial begin
    int w;
    n_tests = 0;
    n_fail  = 0;
    last_m  = 4;
    reset   = 1'b1;
    reqs    = 5'b00000;
    ack     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_acks", 32'(bus.acks_in), 32'd0);
    chk("rst_req", 32'(bus.req_out), 32'd0);
    chk("rst_active", 32'(bus.active), 32'd0);
    chk("rst_sel", 32'(bus.selected), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Reset while a connection is in GRANT
    reqs = 5'b00100;
    expect_grant();
    wait_grant(w);
    #2 reset = 1'b1;
    #1;
    chk("arst_req", 32'(bus.req_out), 32'd0);
    chk("arst_active", 32'(bus.active), 32'd0);
    chk("arst_acks", 32'(bus.acks_in), 32'd0);
    chk("arst_sel", 32'(bus.selected), 32'd0);
    reqs = 5'b00000;
    @(negedge clk);
    reset  = 1'b0;
    last_m = 4;
    @(negedge clk);

    // Port 0 first after reset
    reqs = 5'b10001;
    expect_grant();
    wait_grant(w);
    chk("post_reset_port0", w, 32'd0);
    finish_conn(w, 1'b0);
    reqs = 5'b00000;
    @(negedge clk);

    // Single request on port 3
    reqs = 5'b01000;
    expect_grant();
    wait_grant(w);
    finish_conn(w, 1'b0);
    reqs = 5'b10000;
    expect_grant();
    wait_grant(w);
    finish_conn(w, 1'b0);

    // All ports requesting, each grant completed and re-requested
    reqs = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      expect_grant();
      wait_grant(w);
`ifdef ARB_FIXED_PRIO_EN
      chk("rr_order", w, 32'd0);
`else
      chk("rr_order", w, 32'(k % 5));
`endif
      finish_conn(w, 1'b1);
    end
    reqs = 5'b00000;
    @(negedge clk);

    // Wrap-around from last=4
    reqs = 5'b10000;
    expect_grant();
    wait_grant(w);
    finish_conn(w, 1'b0);
    reqs = 5'b00011;
    expect_grant();
    wait_grant(w);
    chk("wrap_first", w, 32'd0);
    finish_conn(w, 1'b1);
    expect_grant();
    wait_grant(w);
`ifdef ARB_FIXED_PRIO_EN
    chk("wrap_second", w, 32'd0);
`else
    chk("wrap_second", w, 32'd1);
`endif
    finish_conn(w, 1'b0);
    reqs = 5'b00000;
    @(negedge clk);

    // Release gating on held request and held ack
    reqs = 5'b00100;
    expect_grant();
    wait_grant(w);
    ack = 1'b1;
    @(negedge clk);
    chk("gate_ack", 32'(bus.acks_in), 32'h04);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("gate_req_held", 32'(bus.acks_in), 32'h04);
    end
    reqs = 5'b00000;
    @(negedge clk);
    chk("gate_ack_held", 32'(bus.acks_in), 32'h04);
    chk("gate_active_held", 32'(bus.active), 32'd1);
    ack = 1'b0;
    @(negedge clk);
    chk("gate_released", 32'(bus.acks_in), 32'd0);
    chk("gate_inactive", 32'(bus.active), 32'd0);
    last_m = w;
    reqs = 5'b00100;
    chk("gate_idle_gap", 32'(bus.req_out), 32'd0);
    expect_grant();
    wait_grant(w);
    finish_conn(w, 1'b0);
    reqs = 5'b00000;
    @(negedge clk);

    // Late requester during GRANT for port 1
    reqs = 5'b00010;
    expect_grant();
    wait_grant(w);
    reqs = 5'b00110;
    repeat (2) begin
      @(negedge clk);
      chk("late_sel_held", 32'(bus.selected), 32'd1);
    end
    finish_conn(w, 1'b0);
    expect_grant();
    wait_grant(w);
    chk("late_port2", w, 32'd2);
    finish_conn(w, 1'b0);
    reqs = 5'b00000;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_output_arbiter.md
Name: switch_output_arbiter

Overview:
- One instance per router output port. It arbitrates among the PORTS RX units requesting this output and connects the winner to the TX unit.
- It drives a 4-phase req/ack handshake toward the TX unit and returns the completion ack to the winning RX unit.
- `selected` and `active` steer the router's data/address crossbar.

Parameters:
- ID, 0, router identifier; used only for trace messages.
- SUBID, 0, output-port index within the router; used only for trace messages.
- PORTS, 5, number of requesting RX inputs; 2..2**PORT_BITS.
- PORT_BITS, 8, width of the `selected` index.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- reqs_in  input  PORTS  bit j = RX j requests this output; level-held until acked.
- acks_in  output  PORTS  bit j = completion ack to RX j; one-hot or zero.
- req_out  output  1  switch request to the TX unit.
- ack_out  input  1  switch grant/done from the TX unit (packet fully read).
- selected  output  PORT_BITS  index of the current/last winner.
- active  output  1  high while a connection is established.

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values: acks_in=0, req_out=0, active=0, selected=0, state=IDLE, last winner pointer = PORTS-1 (so port 0 has first priority).
- All outputs are registered; no combinational path from inputs to outputs.

States:
- IDLE: active=0, req_out=0, acks_in=0.
  - If reqs_in!=0 at an edge, pick winner w round-robin, starting at (last+1) mod PORTS and wrapping at PORTS-1 to 0.
  - Same edge: selected<=w, active<=1, req_out<=1, go GRANT. Latency from req sampled to req_out high: 1 cycle.
- GRANT: hold req_out=1, active=1.
  - When ack_out=1 at an edge: req_out<=0, acks_in<=one-hot(w), go RELEASE.
  - reqs_in[w] dropping in GRANT is a protocol violation by the requester and is ignored; the arbiter still waits for ack_out.
- RELEASE: hold acks_in[w]=1, active=1.
  - When reqs_in[w]=0 and ack_out=0 at the same edge: acks_in<=0, active<=0, last<=w, go IDLE.
  - `selected` keeps w after release.
- Throughput: at least one IDLE cycle between connections, so a new grant never occurs on the release edge.
- Changes on non-winning reqs_in are ignored until IDLE.
- Reset asserted in any state returns all outputs to reset values immediately. The pending connection is dropped and is not resumed.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: the lowest-index requesting port always wins; the last pointer is unused.
- Undefined (default): round-robin as described above.
- Handshake timing is identical in both modes.

Decomposition:
- Shared package switch_arb_pkg holds:
  - state enum {IDLE, GRANT, RELEASE} with 2-bit encoding;
  - the RESET_LAST = PORTS-1 convention.
- One sub-module, arb_rr_picker: combinational (reqs_in, last) -> (winner index, any).
  - Implements both the rotate-and-find-first and the fixed-priority variants under the macro.

Test Plan:
- Reset: assert reset mid-GRANT with reqs_in=5'b00100 -> req_out=0, active=0, acks_in=0, selected=0 asynchronously. After release, port 0 wins first when requesting.
- Single request: reqs_in=5'b01000 -> next edge selected=3, active=1, req_out=1. Pulse ack_out 1 cycle -> acks_in=5'b01000 until reqs_in[3] drops, then active=0.
- Round-robin: reqs_in=5'b11111 held, each grant completed -> grant order 0,1,2,3,4,0. With ARB_FIXED_PRIO_EN -> 0,0,0,...
- Wrap-around: last=4, reqs_in=5'b00011 -> selected=0. Then last=0, reqs_in=5'b00011 -> selected=1.
- Release gating: after ack, keep reqs_in[w]=1 for 3 cycles, and keep ack_out=1 one extra cycle after reqs_in[w] drops -> acks_in stays asserted until both are low, then one IDLE cycle before the next grant.
- Late requester: reqs_in[2] rises during GRANT for port 1 -> no change to selected until IDLE, then port 2 granted.
